// File: rtl/ddfs_channel_cfg_sequencer.sv
// DDFS channel configuration sequencer: loads one frequency setting into
// the selected channels over a shared bus, then optionally re-aligns their phase.
module ddfs_channel_cfg_sequencer #(
    parameter int N_CH        = 3,
    parameter int FW_W        = 7,
    parameter int FC_W        = 3,
    parameter int ACK_TIMEOUT = 16,
    parameter bit SYNC_EN     = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [FW_W-1:0] cfg_fw,
    input  logic [FC_W-1:0] cfg_fc,
    input  logic [N_CH-1:0] cfg_mask,
    output logic [FW_W-1:0] bus_fw,
    output logic [FC_W-1:0] bus_fc,
    output logic [N_CH-1:0] ch_load,
    input  logic [N_CH-1:0] ch_ack,
    output logic [N_CH-1:0] phase_clr,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] err_ch
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [N_CH-1:0]  ONE     = N_CH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SYNC,
        DONE
    } state_t;

    state_t          state;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] loaded;
    logic [CNT_W-1:0] cnt;

    logic            accept;
    logic            hit;
    logic            expire;
    logic [N_CH-1:0] pend_next;
    logic [N_CH-1:0] loaded_next;
    logic [N_CH-1:0] first_cfg;
    logic [N_CH-1:0] first_next;

    // Handshake status and next-channel selection (lowest set bit first).
    assign cfg_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = cfg_valid & cfg_ready;
    assign hit         = |(ch_ack & ch_load);
    assign expire      = (cnt == CNT_MAX);
    assign pend_next   = pending & ~ch_load;
    assign loaded_next = hit ? (loaded | ch_load) : loaded;
    assign first_cfg   = cfg_mask & (~cfg_mask + ONE);
    assign first_next  = pend_next & (~pend_next + ONE);

    // Sequencer FSM with registered bus, load, clear and done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            loaded    <= '0;
            cnt       <= '0;
            bus_fw    <= '0;
            bus_fc    <= '0;
            ch_load   <= '0;
            phase_clr <= '0;
            done      <= 1'b0;
            err_ch    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase_clr <= '0;
                    done      <= 1'b0;
                    if (accept) begin
                        bus_fw  <= cfg_fw;
                        bus_fc  <= cfg_fc;
                        pending <= cfg_mask;
                        loaded  <= '0;
                        err_ch  <= '0;
                        cnt     <= '0;
                        if (cfg_mask != '0) begin
                            ch_load <= first_cfg;
                            state   <= LOAD;
                        end else begin
                            ch_load <= '0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (hit || expire) begin
                        pending <= pend_next;
                        loaded  <= loaded_next;
                        cnt     <= '0;
                        if (!hit) begin
                            err_ch <= err_ch | ch_load;
                        end
                        if (pend_next != '0) begin
                            ch_load <= first_next;
                        end else begin
                            ch_load <= '0;
                            if (SYNC_EN) begin
                                phase_clr <= loaded_next;
                                state     <= SYNC;
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SYNC: begin
                    phase_clr <= '0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddfs_channel_cfg_sequencer.sv
// Directed self-checking bench for ddfs_channel_cfg_sequencer.
// Channels answer through a mask-controlled same-cycle ack responder.
module tb_ddfs_channel_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [6:0] cfg_fw = '0;
    logic [2:0] cfg_fc = '0;
    logic [2:0] cfg_mask = '0;
    logic [6:0] bus_fw;
    logic [2:0] bus_fc;
    logic [2:0] ch_load;
    logic [2:0] ch_ack;
    logic [2:0] phase_clr;
    logic       busy;
    logic       done;
    logic [2:0] err_ch;

    logic [2:0] ack_en = 3'b000;
    logic [2:0] ack_force = 3'b000;

    int n_total = 0;
    int n_pass = 0;

    assign ch_ack = (ch_load & ack_en) | ack_force;

    always #5 clk = ~clk;

    ddfs_channel_cfg_sequencer #(
        .N_CH(3), .FW_W(7), .FC_W(3), .ACK_TIMEOUT(16), .SYNC_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_fw(cfg_fw), .cfg_fc(cfg_fc), .cfg_mask(cfg_mask),
        .bus_fw(bus_fw), .bus_fc(bus_fc),
        .ch_load(ch_load), .ch_ack(ch_ack),
        .phase_clr(phase_clr), .busy(busy), .done(done),
        .err_ch(err_ch)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a setting for one edge; returns in the cycle after acceptance.
    task automatic offer(input logic [6:0] fw, input logic [2:0] fc,
                         input logic [2:0] mask);
        cfg_fw = fw;
        cfg_fc = fc;
        cfg_mask = mask;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_total++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_ctl ready/busy/done=%b%b%b exp=100", cfg_ready, busy, done);
        else n_pass++;
        n_total++;
        if (bus_fw !== 7'h00 || bus_fc !== 3'd0)
            $display("FAIL rst_bus fw=%h fc=%h exp=00/0", bus_fw, bus_fc);
        else n_pass++;
        n_total++;
        if (ch_load !== 3'b000 || phase_clr !== 3'b000 || err_ch !== 3'b000)
            $display("FAIL rst_ch load=%b clr=%b err=%b exp=000", ch_load, phase_clr, err_ch);
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_two_channels();
        ack_en = 3'b111;
        offer(7'h2A, 3'd4, 3'b101);
        n_total++;
        if (ch_load !== 3'b001 || busy !== 1'b1 || cfg_ready !== 1'b0)
            $display("FAIL two_t1 load=%b busy=%b rdy=%b exp=001/1/0", ch_load, busy, cfg_ready);
        else n_pass++;
        n_total++;
        if (bus_fw !== 7'h2A || bus_fc !== 3'd4)
            $display("FAIL two_bus1 fw=%h fc=%0d exp=2a/4", bus_fw, bus_fc);
        else n_pass++;
        step();
        n_total++;
        if (ch_load !== 3'b100 || bus_fw !== 7'h2A)
            $display("FAIL two_t2 load=%b fw=%h exp=100/2a", ch_load, bus_fw);
        else n_pass++;
        step();
        n_total++;
        if (phase_clr !== 3'b101 || ch_load !== 3'b000 || done !== 1'b0)
            $display("FAIL two_t3 clr=%b load=%b done=%b exp=101/000/0", phase_clr, ch_load, done);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b1 || phase_clr !== 3'b000 || busy !== 1'b1)
            $display("FAIL two_t4 done=%b clr=%b busy=%b exp=1/000/1", done, phase_clr, busy);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 || err_ch !== 3'b000)
            $display("FAIL two_t5 done=%b rdy=%b busy=%b err=%b exp=0/1/0/000",
                     done, cfg_ready, busy, err_ch);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int c0 = 0;
        int c1 = 0;
        int c2 = 0;
        int cyc = 0;
        logic [2:0] clr_seen = 3'b000;
        logic done_seen = 1'b0;
        ack_en = 3'b101;
        offer(7'h05, 3'd1, 3'b111);
        while (cyc < 60 && !done_seen) begin
            if (ch_load === 3'b001) c0++;
            if (ch_load === 3'b010) c1++;
            if (ch_load === 3'b100) c2++;
            if (phase_clr !== 3'b000) clr_seen = phase_clr;
            if (done === 1'b1) done_seen = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        n_total++;
        if (done_seen !== 1'b1 || cyc !== 19)
            $display("FAIL to_done seen=%b cycles=%0d exp=1/19", done_seen, cyc);
        else n_pass++;
        n_total++;
        if (c1 !== 16)
            $display("FAIL to_len ch1_cycles=%0d exp=16", c1);
        else n_pass++;
        n_total++;
        if (c0 !== 1 || c2 !== 1)
            $display("FAIL to_others ch0=%0d ch2=%0d exp=1/1", c0, c2);
        else n_pass++;
        n_total++;
        if (clr_seen !== 3'b101)
            $display("FAIL to_clr clr=%b exp=101", clr_seen);
        else n_pass++;
        n_total++;
        if (err_ch !== 3'b010)
            $display("FAIL to_err err=%b exp=010", err_ch);
        else n_pass++;
        step();
        n_total++;
        if (err_ch !== 3'b010 || cfg_ready !== 1'b1)
            $display("FAIL to_sticky err=%b rdy=%b exp=010/1", err_ch, cfg_ready);
        else n_pass++;
    endtask

    task automatic test_empty_mask();
        ack_en = 3'b111;
        offer(7'h33, 3'd6, 3'b000);
        n_total++;
        if (done !== 1'b1 || ch_load !== 3'b000 || phase_clr !== 3'b000)
            $display("FAIL empty_t1 done=%b load=%b clr=%b exp=1/000/000", done, ch_load, phase_clr);
        else n_pass++;
        n_total++;
        if (err_ch !== 3'b000)
            $display("FAIL empty_errclr err=%b exp=000", err_ch);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b0 || cfg_ready !== 1'b1 || phase_clr !== 3'b000)
            $display("FAIL empty_t2 done=%b rdy=%b clr=%b exp=0/1/000", done, cfg_ready, phase_clr);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        ack_en = 3'b111;
        offer(7'h11, 3'd2, 3'b011);
        cfg_fw = 7'h55;
        cfg_fc = 3'd7;
        cfg_mask = 3'b100;
        cfg_valid = 1'b1;
        n_total++;
        if (ch_load !== 3'b001 || bus_fw !== 7'h11)
            $display("FAIL ign_t1 load=%b fw=%h exp=001/11", ch_load, bus_fw);
        else n_pass++;
        step();
        n_total++;
        if (ch_load !== 3'b010 || bus_fw !== 7'h11 || bus_fc !== 3'd2)
            $display("FAIL ign_t2 load=%b fw=%h fc=%0d exp=010/11/2", ch_load, bus_fw, bus_fc);
        else n_pass++;
        step();
        n_total++;
        if (phase_clr !== 3'b011 || ch_load !== 3'b000)
            $display("FAIL ign_t3 clr=%b load=%b exp=011/000", phase_clr, ch_load);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b1 || cfg_ready !== 1'b0)
            $display("FAIL ign_t4 done=%b rdy=%b exp=1/0", done, cfg_ready);
        else n_pass++;
        cfg_valid = 1'b0;
        step();
        n_total++;
        if (busy !== 1'b0 || bus_fw !== 7'h11 || bus_fc !== 3'd2)
            $display("FAIL ign_t5 busy=%b fw=%h fc=%0d exp=0/11/2", busy, bus_fw, bus_fc);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b0 || ch_load !== 3'b000)
            $display("FAIL ign_noqueue busy=%b load=%b exp=0/000", busy, ch_load);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        ack_en = 3'b111;
        offer(7'h40, 3'd3, 3'b100);
        n_total++;
        if (ch_load !== 3'b100)
            $display("FAIL b2b_load load=%b exp=100", ch_load);
        else n_pass++;
        step();
        n_total++;
        if (phase_clr !== 3'b100)
            $display("FAIL b2b_clr clr=%b exp=100", phase_clr);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b1)
            $display("FAIL b2b_done done=%b exp=1", done);
        else n_pass++;
        step();
        n_total++;
        if (cfg_ready !== 1'b1)
            $display("FAIL b2b_ready rdy=%b exp=1", cfg_ready);
        else n_pass++;
        offer(7'h21, 3'd5, 3'b001);
        n_total++;
        if (ch_load !== 3'b001 || bus_fw !== 7'h21)
            $display("FAIL b2b_second load=%b fw=%h exp=001/21", ch_load, bus_fw);
        else n_pass++;
        step();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        ack_en = 3'b001;
        offer(7'h3C, 3'd1, 3'b111);
        step();
        n_total++;
        if (ch_load !== 3'b010)
            $display("FAIL rmid_pre load=%b exp=010", ch_load);
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_total++;
        if (ch_load !== 3'b000 || busy !== 1'b0 || cfg_ready !== 1'b1 || bus_fw !== 7'h00)
            $display("FAIL rmid_post load=%b busy=%b rdy=%b fw=%h exp=000/0/1/00",
                     ch_load, busy, cfg_ready, bus_fw);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0 || phase_clr !== 3'b000) bad = 1'b1;
            step();
        end
        n_total++;
        if (bad !== 1'b0)
            $display("FAIL rmid_quiet done/clr seen after reset=%b exp=0", bad);
        else n_pass++;
    endtask

    task automatic test_ack_last_cycle();
        logic bad = 1'b0;
        ack_en = 3'b000;
        offer(7'h7F, 3'd5, 3'b010);
        for (int i = 1; i < 16; i++) begin
            if (ch_load !== 3'b010) bad = 1'b1;
            step();
        end
        if (ch_load !== 3'b010) bad = 1'b1;
        n_total++;
        if (bad !== 1'b0)
            $display("FAIL last_hold ch_load dropped early=%b exp=0", bad);
        else n_pass++;
        ack_force = 3'b010;
        step();
        ack_force = 3'b000;
        n_total++;
        if (phase_clr !== 3'b010 || err_ch !== 3'b000 || ch_load !== 3'b000)
            $display("FAIL last_win clr=%b err=%b load=%b exp=010/000/000",
                     phase_clr, err_ch, ch_load);
        else n_pass++;
        step();
        n_total++;
        if (done !== 1'b1 || err_ch !== 3'b000)
            $display("FAIL last_done done=%b err=%b exp=1/000", done, err_ch);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_two_channels();
        test_timeout();
        test_empty_mask();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_ack_last_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
